// File: rtl/mc_control_fsm_pkg.sv
// ----------------------------------------------------------------------------
// mc_control_fsm_pkg
// Shared definitions for the multicycle RV32I main control FSM: state codes,
// major-opcode constants, datapath select encodings, the control-word struct
// and the opcode-to-state decode used in DECODE.
// ----------------------------------------------------------------------------
package mc_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALRADR  = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_ILL      = 4'd14,
    S_TRAP     = 4'd15
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_A_ZERO  = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       we_mem;
    logic       sel_mem_addr;
    logic       we_ir;
    logic       pc_update;
    logic       branch;
    logic [1:0] alu_op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] sel_result;
    logic       we_rf;
    logic       retire;
  } ctrl_t;

  // Branches with a reserved funct3 are routed to ILL straight from DECODE so
  // that BRANCH never issues a PC write request for them.
  function automatic state_e decode_op(input logic [6:0] op, input logic bad_funct3);
    state_e nxt;
    case (op)
      OP_LOAD,
      OP_STORE:  nxt = S_MEMADR;
      OP_BRANCH: nxt = bad_funct3 ? S_ILL : S_BRANCH;
      OP_IMM:    nxt = S_EXECI;
      OP_REG:    nxt = S_EXECR;
      OP_JAL:    nxt = S_JAL;
      OP_JALR:   nxt = S_JALRADR;
      OP_LUI:    nxt = S_LUI;
      OP_AUIPC:  nxt = S_AUIPC;
      default:   nxt = S_ILL;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_control_fsm_branch_cond.sv
// ----------------------------------------------------------------------------
// mc_control_fsm_branch_cond
// Combinational branch-condition evaluation from funct3 and the ALU compare
// flags.
//   funct3     in  3  branch type from IR
//   zero       in  1  ALU result == 0
//   lt         in  1  signed rs1 < rs2
//   ltu        in  1  unsigned rs1 < rs2
//   taken      out 1  branch condition holds
//   bad_funct3 out 1  funct3 is 010/011 (no such branch)
// ----------------------------------------------------------------------------
module mc_control_fsm_branch_cond (
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  output logic       taken,
  output logic       bad_funct3
);

  always_comb begin
    taken      = 1'b0;
    bad_funct3 = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: bad_funct3 = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// ----------------------------------------------------------------------------
// mc_control_fsm
// Main control FSM for the multicycle RV32I datapath with variable-latency
// memory (req/ready), full conditional branches, JALR, AUIPC and an
// illegal-instruction trap.
// Parameters:
//   MEM_WAIT_EN  1: memory states hold until mem_ready; 0: mem_ready ignored
//   TRAP_EN      1: illegal instruction -> sticky TRAP; 0: retires as NOP
//   STATE_W      width of state_o (>= 4)
// Ports:
//   clk, reset (async, active-low)
//   op, funct3           instruction fields from IR
//   zero, lt, ltu        ALU flags
//   mem_ready            memory completes current request
//   mem_req, we_mem, sel_mem_addr       memory interface controls
//   we_ir, pc_update, branch, we_pc     IR / PC write controls
//   alu_op, sel_alu_src_a/b, sel_result datapath selects
//   we_rf, retire, illegal, state_o     writeback, status, debug
//
// state     | meaning
// ----------+-----------------------------------------------------
// FETCH     | read instr at PC, PC += 4 when memory is ready
// DECODE    | OldPC + imm into ALUOut, dispatch on opcode
// MEMADR    | rs1 + imm -> ALUOut (load/store address)
// MEMREAD   | load request, wait for ready
// MEMWB     | load data -> rd
// MEMWRITE  | store request, wait for ready, retire
// EXECR     | rs1 op rs2
// EXECI     | rs1 op imm
// LUI       | 0 + imm
// AUIPC     | OldPC + imm
// JALRADR   | rs1 + imm -> ALUOut (jump target)
// JAL       | PC <= ALUOut, OldPC + 4 -> ALUOut
// ALUWB     | ALUOut -> rd
// BRANCH    | compare, PC <= target if taken
// ILL       | illegal instruction seen
// TRAP      | halted until reset
// ----------------------------------------------------------------------------
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter bit          MEM_WAIT_EN = 1'b1,
  parameter bit          TRAP_EN     = 1'b1,
  parameter int unsigned STATE_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               zero,
  input  logic               lt,
  input  logic               ltu,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               we_mem,
  output logic               sel_mem_addr,
  output logic               we_ir,
  output logic               pc_update,
  output logic               branch,
  output logic               we_pc,
  output logic [1:0]         alu_op,
  output logic [1:0]         sel_alu_src_a,
  output logic [1:0]         sel_alu_src_b,
  output logic [1:0]         sel_result,
  output logic               we_rf,
  output logic               retire,
  output logic               illegal,
  output logic [STATE_W-1:0] state_o
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   ready;
  logic   taken;
  logic   bad_funct3;
  ctrl_t  ctl;

  assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

  mc_control_fsm_branch_cond u_branch_cond (
    .funct3     (funct3),
    .zero       (zero),
    .lt         (lt),
    .ltu        (ltu),
    .taken      (taken),
    .bad_funct3 (bad_funct3)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:    if (ready) state_d = S_DECODE;
      S_DECODE:   state_d = decode_op(op, bad_funct3);
      S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (ready) state_d = S_FETCH;
      S_EXECR,
      S_EXECI,
      S_LUI,
      S_AUIPC:    state_d = S_ALUWB;
      S_JALRADR:  state_d = S_JAL;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_ILL:      state_d = TRAP_EN ? S_TRAP : S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
    // Flag is raised on the edge that enters TRAP, so it reads 1 for the
    // whole time the FSM sits there.
    if (state_d == S_TRAP) illegal_d = 1'b1;
  end

  // Output decode: Moore, except ready gating in FETCH/MEMWRITE and the
  // taken qualification of we_pc.
  always_comb begin
    ctl = '0;
    case (state_q)
      S_FETCH: begin
        ctl.mem_req    = 1'b1;
        ctl.src_a      = SRC_A_PC;
        ctl.src_b      = SRC_B_FOUR;
        ctl.sel_result = RES_ALU;
        ctl.we_ir      = ready;
        ctl.pc_update  = ready;
      end
      S_DECODE: begin
        ctl.src_a  = SRC_A_OLDPC;
        ctl.src_b  = SRC_B_IMM;
        ctl.alu_op = ALU_ADD;
      end
      S_MEMADR: begin
        ctl.src_a  = SRC_A_RS1;
        ctl.src_b  = SRC_B_IMM;
        ctl.alu_op = ALU_ADD;
      end
      S_MEMREAD: begin
        ctl.mem_req      = 1'b1;
        ctl.sel_mem_addr = 1'b1;
      end
      S_MEMWB: begin
        ctl.sel_result = RES_MEM;
        ctl.we_rf      = 1'b1;
        ctl.retire     = 1'b1;
      end
      S_MEMWRITE: begin
        ctl.mem_req      = 1'b1;
        ctl.we_mem       = 1'b1;
        ctl.sel_mem_addr = 1'b1;
        ctl.retire       = ready;
      end
      S_EXECR: begin
        ctl.src_a  = SRC_A_RS1;
        ctl.src_b  = SRC_B_RS2;
        ctl.alu_op = ALU_FUNCT;
      end
      S_EXECI: begin
        ctl.src_a  = SRC_A_RS1;
        ctl.src_b  = SRC_B_IMM;
        ctl.alu_op = ALU_FUNCT;
      end
      S_LUI: begin
        ctl.src_a  = SRC_A_ZERO;
        ctl.src_b  = SRC_B_IMM;
        ctl.alu_op = ALU_ADD;
      end
      S_AUIPC: begin
        ctl.src_a  = SRC_A_OLDPC;
        ctl.src_b  = SRC_B_IMM;
        ctl.alu_op = ALU_ADD;
      end
      S_JALRADR: begin
        ctl.src_a  = SRC_A_RS1;
        ctl.src_b  = SRC_B_IMM;
        ctl.alu_op = ALU_ADD;
      end
      S_JAL: begin
        // PC takes the target already in ALUOut; ALU forms the link address.
        ctl.src_a      = SRC_A_OLDPC;
        ctl.src_b      = SRC_B_FOUR;
        ctl.alu_op     = ALU_ADD;
        ctl.sel_result = RES_ALUOUT;
        ctl.pc_update  = 1'b1;
      end
      S_ALUWB: begin
        ctl.sel_result = RES_ALUOUT;
        ctl.we_rf      = 1'b1;
        ctl.retire     = 1'b1;
      end
      S_BRANCH: begin
        ctl.src_a  = SRC_A_RS1;
        ctl.src_b  = SRC_B_RS2;
        ctl.alu_op = ALU_SUB;
        ctl.branch = 1'b1;
        ctl.retire = 1'b1;
      end
      S_ILL: begin
        // Without trapping, the bad instruction retires with no writes.
        ctl.retire = (TRAP_EN == 1'b0);
      end
      default: ctl = '0;
    endcase
  end

  assign mem_req       = ctl.mem_req;
  assign we_mem        = ctl.we_mem;
  assign sel_mem_addr  = ctl.sel_mem_addr;
  assign we_ir         = ctl.we_ir;
  assign pc_update     = ctl.pc_update;
  assign branch        = ctl.branch;
  assign we_pc         = (ctl.branch & taken) | ctl.pc_update;
  assign alu_op        = ctl.alu_op;
  assign sel_alu_src_a = ctl.src_a;
  assign sel_alu_src_b = ctl.src_b;
  assign sel_result    = ctl.sel_result;
  assign we_rf         = ctl.we_rf;
  assign retire        = ctl.retire;
  assign illegal       = illegal_q;
  assign state_o       = STATE_W'(state_q);

endmodule
